// File: rtl/pipe_fft_dly_line.sv
`default_nettype none
// ============================================================================
// Module      : pipe_fft_dly_line
// Description : Self-addressing, run-time programmable delay line (0..DEPTH
//               samples) with fill tracking, valid strobe and flush on load.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_fft_dly_line #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 64,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             cfg_ld,
    input  logic [LW-1:0]    dly_len,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             primed,
    output logic             cfg_err
);

    localparam int            c_PW       = $clog2(DEPTH);
    localparam logic [LW-1:0] c_DEPTH_L  = LW'(DEPTH);
    localparam logic [c_PW-1:0] c_LAST_PTR = c_PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [LW-1:0]    r_fill;
    logic [LW-1:0]    r_len;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_vld;
    logic             r_cfg_err;

    logic             w_accept;
    logic             w_hit;
    logic [c_PW-1:0]  w_back;
    logic [c_PW-1:0]  w_rd_addr;
    logic [WIDTH-1:0] w_next_dout;

    assign w_accept = en & ~cfg_ld & ~rst;
    assign w_hit    = (r_fill >= r_len);

    // Read address = (wptr - L) mod DEPTH without needing a power-of-two DEPTH.
    assign w_back    = c_PW'(c_DEPTH_L - r_len);
    assign w_rd_addr = (LW'(r_wptr) >= r_len) ? (r_wptr - c_PW'(r_len))
                                              : (r_wptr + w_back);

    always_comb begin
        w_next_dout = '0;
        if (r_len == '0) begin
            w_next_dout = din;
        end else if (w_hit) begin
            w_next_dout = r_mem[w_rd_addr];
        end
    end

    // Storage is never reset; the old word is read in the same edge it is overwritten.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= c_DEPTH_L;
            r_wptr     <= '0;
            r_fill     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else if (cfg_ld) begin
            if (dly_len > c_DEPTH_L) begin
                r_len     <= c_DEPTH_L;
                r_cfg_err <= 1'b1;
            end else begin
                r_len     <= dly_len;
                r_cfg_err <= 1'b0;
            end
            r_wptr     <= '0;
            r_fill     <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else if (en) begin
            r_wptr     <= (r_wptr == c_LAST_PTR) ? '0 : r_wptr + 1'b1;
            r_fill     <= (r_fill == c_DEPTH_L) ? r_fill : r_fill + 1'b1;
            r_dout     <= w_next_dout;
            r_dout_vld <= w_hit;
        end else begin
            r_dout_vld <= 1'b0;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign primed   = w_hit;
    assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_fft_dly_line.sv
`default_nettype none
// Directed testbench for pipe_fft_dly_line (WIDTH=68, DEPTH=64).
module tb_pipe_fft_dly_line;

    localparam int W  = 68;
    localparam int D  = 64;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [W-1:0]  din;
    logic          cfg_ld;
    logic [LW-1:0] dly_len;
    logic [W-1:0]  dout;
    logic          dout_vld;
    logic          primed;
    logic          cfg_err;

    int checks   = 0;
    int failures = 0;

    pipe_fft_dly_line #(.WIDTH(W), .DEPTH(D), .LW(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .cfg_ld   (cfg_ld),
        .dly_len  (dly_len),
        .dout     (dout),
        .dout_vld (dout_vld),
        .primed   (primed),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic e, input logic [W-1:0] d, input logic ld, input logic [LW-1:0] l);
        en = e; din = d; cfg_ld = ld; dly_len = l;
        @(posedge clk);
        #1;
        en = 1'b0; cfg_ld = 1'b0;
    endtask

    task automatic test_reset;
        checks += 4;
        if (dout !== '0)     begin failures++; $display("FAIL reset_dout got=%0h exp=0", dout); end
        if (dout_vld !== 0)  begin failures++; $display("FAIL reset_vld got=%0b exp=0", dout_vld); end
        if (primed !== 0)    begin failures++; $display("FAIL reset_primed got=%0b exp=0", primed); end
        if (cfg_err !== 0)   begin failures++; $display("FAIL reset_cfg_err got=%0b exp=0", cfg_err); end
    endtask

    task automatic test_full_depth;
        logic [W-1:0] exp_d;
        step(0, '0, 1, 7'd64);
        checks++;
        if (primed !== 0) begin failures++; $display("FAIL full_primed_load got=%0b exp=0", primed); end
        for (int k = 0; k < 70; k++) begin
            step(1, W'(k), 0, '0);
            exp_d = (k >= 64) ? W'(k - 64) : '0;
            checks += 3;
            if (dout_vld !== (k >= 64)) begin failures++; $display("FAIL full_vld k=%0d got=%0b exp=%0b", k, dout_vld, k >= 64); end
            if (dout !== exp_d)         begin failures++; $display("FAIL full_dout k=%0d got=%0h exp=%0h", k, dout, exp_d); end
            if (primed !== (k >= 63))   begin failures++; $display("FAIL full_primed k=%0d got=%0b exp=%0b", k, primed, k >= 63); end
        end
    endtask

    task automatic test_gaps;
        int s = 0;
        logic [W-1:0] last = '0;
        logic [W-1:0] exp_d;
        step(0, '0, 1, 7'd5);
        for (int c = 0; c < 60 && s <= 20; c++) begin
            if ((c % 4 == 0) || (c % 4 == 3)) begin
                step(1, W'(s), 0, '0);
                exp_d = (s >= 5) ? W'(s - 5) : '0;
                checks += 3;
                if (dout_vld !== (s >= 5))    begin failures++; $display("FAIL gap_vld s=%0d got=%0b exp=%0b", s, dout_vld, s >= 5); end
                if (dout !== exp_d)           begin failures++; $display("FAIL gap_dout s=%0d got=%0h exp=%0h", s, dout, exp_d); end
                if (primed !== (s + 1 >= 5))  begin failures++; $display("FAIL gap_primed s=%0d got=%0b exp=%0b", s, primed, s + 1 >= 5); end
                last = exp_d;
                s++;
            end else begin
                step(0, W'(68'hdead), 0, '0);
                checks += 2;
                if (dout_vld !== 0) begin failures++; $display("FAIL gap_idle_vld c=%0d got=%0b exp=0", c, dout_vld); end
                if (dout !== last)  begin failures++; $display("FAIL gap_hold c=%0d got=%0h exp=%0h", c, dout, last); end
            end
        end
    endtask

    task automatic test_bypass;
        step(0, '0, 1, 7'd0);
        checks += 2;
        if (primed !== 1) begin failures++; $display("FAIL byp_primed got=%0b exp=1", primed); end
        if (dout !== '0)  begin failures++; $display("FAIL byp_load_dout got=%0h exp=0", dout); end
        step(1, W'(8'hA5), 0, '0);
        checks += 2;
        if (dout !== W'(8'hA5)) begin failures++; $display("FAIL byp_dout got=%0h exp=a5", dout); end
        if (dout_vld !== 1)     begin failures++; $display("FAIL byp_vld got=%0b exp=1", dout_vld); end
        step(0, W'(8'h11), 0, '0);
        checks += 2;
        if (dout !== W'(8'hA5)) begin failures++; $display("FAIL byp_hold got=%0h exp=a5", dout); end
        if (dout_vld !== 0)     begin failures++; $display("FAIL byp_idle_vld got=%0b exp=0", dout_vld); end
        step(1, W'(8'h3C), 0, '0);
        checks++;
        if (dout !== W'(8'h3C)) begin failures++; $display("FAIL byp_dout2 got=%0h exp=3c", dout); end
    endtask

    task automatic test_cfg_err;
        step(0, '0, 1, 7'd70);
        checks++;
        if (cfg_err !== 1) begin failures++; $display("FAIL err_set got=%0b exp=1", cfg_err); end
        for (int k = 0; k < 65; k++) begin
            step(1, W'(100 + k), 0, '0);
            if (k == 63) begin
                checks++;
                if (dout_vld !== 0) begin failures++; $display("FAIL err_vld63 got=%0b exp=0", dout_vld); end
            end
            if (k == 64) begin
                checks += 2;
                if (dout_vld !== 1)   begin failures++; $display("FAIL err_vld64 got=%0b exp=1", dout_vld); end
                if (dout !== W'(100)) begin failures++; $display("FAIL err_dout64 got=%0h exp=64", dout); end
            end
        end
        step(0, '0, 1, 7'd3);
        checks++;
        if (cfg_err !== 0) begin failures++; $display("FAIL err_clear got=%0b exp=0", cfg_err); end
        for (int j = 0; j < 4; j++) begin
            step(1, W'(500 + j), 0, '0);
            checks++;
            if (dout_vld !== (j == 3)) begin failures++; $display("FAIL err_l3_vld j=%0d got=%0b exp=%0b", j, dout_vld, j == 3); end
        end
        checks++;
        if (dout !== W'(500)) begin failures++; $display("FAIL err_l3_dout got=%0h exp=1f4", dout); end
    endtask

    task automatic test_flush;
        step(0, '0, 1, 7'd16);
        for (int k = 0; k < 40; k++) step(1, W'(k), 0, '0);
        checks += 2;
        if (dout !== W'(23)) begin failures++; $display("FAIL flush_pre_dout got=%0h exp=17", dout); end
        if (dout_vld !== 1)  begin failures++; $display("FAIL flush_pre_vld got=%0b exp=1", dout_vld); end
        step(1, W'(999), 1, 7'd8);
        checks += 3;
        if (dout !== '0)    begin failures++; $display("FAIL flush_dout got=%0h exp=0", dout); end
        if (dout_vld !== 0) begin failures++; $display("FAIL flush_vld got=%0b exp=0", dout_vld); end
        if (primed !== 0)   begin failures++; $display("FAIL flush_primed got=%0b exp=0", primed); end
        for (int j = 0; j < 9; j++) begin
            step(1, W'(200 + j), 0, '0);
            checks++;
            if (dout_vld !== (j == 8)) begin failures++; $display("FAIL flush_post_vld j=%0d got=%0b exp=%0b", j, dout_vld, j == 8); end
        end
        checks++;
        if (dout !== W'(200)) begin failures++; $display("FAIL flush_post_dout got=%0h exp=c8", dout); end
    endtask

    task automatic test_reset_mid;
        step(0, '0, 1, 7'd4);
        for (int k = 0; k < 10; k++) step(1, W'(k), 0, '0);
        checks++;
        if (dout !== W'(5)) begin failures++; $display("FAIL rmid_pre_dout got=%0h exp=5", dout); end
        rst = 1'b1;
        step(1, W'(77), 0, '0);
        rst = 1'b0;
        checks += 4;
        if (dout !== '0)    begin failures++; $display("FAIL rmid_dout got=%0h exp=0", dout); end
        if (dout_vld !== 0) begin failures++; $display("FAIL rmid_vld got=%0b exp=0", dout_vld); end
        if (primed !== 0)   begin failures++; $display("FAIL rmid_primed got=%0b exp=0", primed); end
        if (cfg_err !== 0)  begin failures++; $display("FAIL rmid_cfg_err got=%0b exp=0", cfg_err); end
        for (int k = 0; k < 65; k++) begin
            step(1, W'(300 + k), 0, '0);
            if (k == 62) begin
                checks += 2;
                if (primed !== 0)   begin failures++; $display("FAIL rmid_primed62 got=%0b exp=0", primed); end
                if (dout_vld !== 0) begin failures++; $display("FAIL rmid_vld62 got=%0b exp=0", dout_vld); end
            end
            if (k == 63) begin
                checks += 2;
                if (primed !== 1)   begin failures++; $display("FAIL rmid_primed63 got=%0b exp=1", primed); end
                if (dout_vld !== 0) begin failures++; $display("FAIL rmid_vld63 got=%0b exp=0", dout_vld); end
            end
            if (k == 64) begin
                checks += 2;
                if (dout_vld !== 1)   begin failures++; $display("FAIL rmid_vld64 got=%0b exp=1", dout_vld); end
                if (dout !== W'(300)) begin failures++; $display("FAIL rmid_dout64 got=%0h exp=12c", dout); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = '0; cfg_ld = 1'b0; dly_len = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        test_full_depth;
        test_gaps;
        test_bypass;
        test_cfg_err;
        test_flush;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
